sram_byte_arbiter: RTL and testbench

// - Shares the single 16-bit external SRAM (word-addressed, one active-low WE, no byte lanes) between two byte-wide requesters.
// - Requester A is the ioctl loader (binROM/CAS download writes). Requester B is the sordM5 core memory port (CPU RAM/ROM-shadow reads and writes).
// - Byte writes are done as read-modify-write of the containing word. Access timing comes from cycle counters at clk_sys.
// - Sits between sordM5 and the SRAM_A/SRAM_Q/SRAM_WE pins. The top level builds the tristate from sram_dq_o/sram_dq_oe.

---
 rtl/sram_byte_arbiter_pkg.sv | 37 +++
 rtl/sram_byte_arbiter_if.sv | 31 +++
 rtl/sram_byte_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_byte_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_byte_arbiter_pkg.sv
// Shared types and helpers for the two-port byte arbiter in front of the 16-bit SRAM.
// Byte lanes are merged here so every user applies the same lane rule.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WSET = 3'd3,
    WPUL = 3'd4,
    WHLD = 3'd5,
    ACK  = 3'd6
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // lane=1 replaces dq[15:8], lane=0 replaces dq[7:0]
  function automatic logic [15:0] merge_byte(input logic [15:0] word16,
                                             input logic [7:0]  byte8,
                                             input logic        lane);
    logic [15:0] w;
    w = word16;
    if (lane) begin
      w[15:8] = byte8;
    end else begin
      w[7:0] = byte8;
    end
    return w;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [15:0] word16,
                                           input logic        lane);
    return lane ? word16[15:8] : word16[7:0];
  endfunction

endpackage

// File: rtl/sram_byte_arbiter_if.sv
// Requester handshakes plus the SRAM pin bundle seen by the byte arbiter.
// slave = arbiter side, master = requesters/SRAM side.
interface sram_byte_arbiter_if #(
  parameter int ADDR_W = 21
);
  logic              a_req;
  logic [ADDR_W:0]   a_addr;
  logic [7:0]        a_din;
  logic              a_ack;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W:0]   b_addr;
  logic [7:0]        b_din;
  logic [7:0]        b_dout;
  logic              b_ack;
  logic [ADDR_W-1:0] sram_a;
  logic [15:0]       sram_dq_i;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic              sram_we_n;

  modport slave (
    input  a_req, a_addr, a_din, b_req, b_we, b_addr, b_din, sram_dq_i,
    output a_ack, b_ack, b_dout, sram_a, sram_dq_o, sram_dq_oe, sram_we_n
  );

  modport master (
    output a_req, a_addr, a_din, b_req, b_we, b_addr, b_din, sram_dq_i,
    input  a_ack, b_ack, b_dout, sram_a, sram_dq_o, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_byte_arbiter.sv
// Round-robin arbiter sharing one 16-bit word SRAM between the loader (A) and the core (B).
// Byte writes are read-modify-write; all timing is counted in clk_sys cycles.
module sram_byte_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = 21,
  parameter int RD_WAIT   = 2,
  parameter int WE_CYCLES = 2
) (
  input  logic                clk_sys,
  input  logic                reset,
  sram_byte_arbiter_if.slave  bus
);

  localparam int MAX_WAIT = (RD_WAIT > WE_CYCLES) ? RD_WAIT : WE_CYCLES;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WE_LOAD  = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  arb_state_t        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              port_r;
  logic              last_grant_r;
  logic              we_r;
  logic              lane_r;
  logic [7:0]        din_r;
  logic [15:0]       word_r;
  logic              merge_phase_r;
  logic              a_ack_r;
  logic              b_ack_r;
  logic [7:0]        b_dout_r;
  logic [ADDR_W-1:0] sram_a_r;
  logic [15:0]       dq_o_r;
  logic              oe_r;
  logic              we_n_r;

  logic              grant_valid_s;
  logic              grant_s;
  logic [ADDR_W:0]   sel_addr_s;
  logic [7:0]        sel_din_s;
  logic              sel_we_s;

  // Request selection: on contention the port that was not served last wins
  always_comb begin
    grant_valid_s = bus.a_req | bus.b_req;
    grant_s       = PORT_B;
    if (bus.a_req && bus.b_req) begin
      grant_s = (last_grant_r == PORT_A) ? PORT_B : PORT_A;
    end else if (bus.a_req) begin
      grant_s = PORT_A;
    end else begin
      grant_s = PORT_B;
    end
    if (grant_s == PORT_A) begin
      sel_addr_s = bus.a_addr;
      sel_din_s  = bus.a_din;
      sel_we_s   = 1'b1;
    end else begin
      sel_addr_s = bus.b_addr;
      sel_din_s  = bus.b_din;
      sel_we_s   = bus.b_we;
    end
  end

  // Transaction FSM with all pin-facing outputs registered
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      port_r        <= PORT_B;
      last_grant_r  <= PORT_B;
      we_r          <= 1'b0;
      lane_r        <= 1'b0;
      din_r         <= 8'h00;
      word_r        <= 16'h0000;
      merge_phase_r <= 1'b0;
      a_ack_r       <= 1'b0;
      b_ack_r       <= 1'b0;
      b_dout_r      <= 8'h00;
      sram_a_r      <= {ADDR_W{1'b0}};
      dq_o_r        <= 16'h0000;
      oe_r          <= 1'b0;
      we_n_r        <= 1'b1;
    end else begin
      a_ack_r <= 1'b0;
      b_ack_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            port_r       <= grant_s;
            last_grant_r <= grant_s;
            we_r         <= sel_we_s;
            lane_r       <= sel_addr_s[0];
            din_r        <= sel_din_s;
            sram_a_r     <= sel_addr_s[ADDR_W:1];
            cnt_r        <= RD_LOAD;
            state_r      <= RD;
          end else begin
            state_r      <= IDLE;
          end
        end
        RD: begin
          if (cnt_r == CNT_ZERO) begin
            merge_phase_r <= 1'b0;
            state_r       <= CAP;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        // Writes spend a second CAP cycle so the merged word is registered before oe rises
        CAP: begin
          if (!we_r) begin
            word_r  <= bus.sram_dq_i;
            if (port_r == PORT_B) begin
              b_dout_r <= pick_byte(bus.sram_dq_i, lane_r);
            end else begin
              b_dout_r <= b_dout_r;
            end
            a_ack_r <= (port_r == PORT_A);
            b_ack_r <= (port_r == PORT_B);
            state_r <= ACK;
          end else if (!merge_phase_r) begin
            word_r        <= bus.sram_dq_i;
            merge_phase_r <= 1'b1;
          end else begin
            dq_o_r  <= merge_byte(word_r, din_r, lane_r);
            oe_r    <= 1'b1;
            we_n_r  <= 1'b1;
            state_r <= WSET;
          end
        end
        WSET: begin
          we_n_r  <= 1'b0;
          cnt_r   <= WE_LOAD;
          state_r <= WPUL;
        end
        WPUL: begin
          if (cnt_r == CNT_ZERO) begin
            we_n_r  <= 1'b1;
            state_r <= WHLD;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        WHLD: begin
          oe_r    <= 1'b0;
          a_ack_r <= (port_r == PORT_A);
          b_ack_r <= (port_r == PORT_B);
          state_r <= ACK;
        end
        ACK: begin
          state_r <= IDLE;
        end
        default: begin
          oe_r    <= 1'b0;
          we_n_r  <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_ack      = a_ack_r;
  assign bus.b_ack      = b_ack_r;
  assign bus.b_dout     = b_dout_r;
  assign bus.sram_a     = sram_a_r;
  assign bus.sram_dq_o  = dq_o_r;
  assign bus.sram_dq_oe = oe_r;
  assign bus.sram_we_n  = we_n_r;

endmodule

// File: tb/tb_sram_byte_arbiter.sv
// Directed bench for sram_byte_arbiter: default instance checked every cycle against a
// byte-level memory model, plus two instances with other timing parameters for latency.
module tb_sram_byte_arbiter;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic mem_load = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk_sys = ~clk_sys;

  sram_byte_arbiter_if #(.ADDR_W(21)) bus0 ();
  sram_byte_arbiter_if #(.ADDR_W(21)) bus1 ();
  sram_byte_arbiter_if #(.ADDR_W(21)) bus2 ();

  sram_byte_arbiter #(.ADDR_W(21), .RD_WAIT(2), .WE_CYCLES(2)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .bus(bus0));
  sram_byte_arbiter #(.ADDR_W(21), .RD_WAIT(1), .WE_CYCLES(1)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .bus(bus1));
  sram_byte_arbiter #(.ADDR_W(21), .RD_WAIT(4), .WE_CYCLES(3)) dut2 (
    .clk_sys(clk_sys), .reset(reset), .bus(bus2));

  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];
  logic [15:0] mem2 [64];
  logic [15:0] exp_mem [64];
  logic [7:0]  exp_b_dout;

  function automatic logic [15:0] init_word(input int i);
    if (i == 1) return 16'hA55A;
    if (i == 8) return 16'h1234;
    return 16'h1000 + 16'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  assign bus0.sram_dq_i = mem0[bus0.sram_a[5:0]];
  assign bus1.sram_dq_i = mem1[bus1.sram_a[5:0]];
  assign bus2.sram_dq_i = mem2[bus2.sram_a[5:0]];

  // SRAM models: asynchronous read, write while we_n is low
  always @(posedge clk_sys) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) begin
        mem0[i] <= init_word(i);
        mem1[i] <= init_word(i);
        mem2[i] <= init_word(i);
      end
    end else begin
      if (!bus0.sram_we_n) mem0[bus0.sram_a[5:0]] <= bus0.sram_dq_o;
      if (!bus1.sram_we_n) mem1[bus1.sram_a[5:0]] <= bus1.sram_dq_o;
      if (!bus2.sram_we_n) mem2[bus2.sram_a[5:0]] <= bus2.sram_dq_o;
    end
  end

  // Compare process: byte-level model of memory contents and of b_dout for the default DUT
  always @(negedge clk_sys) begin
    int w;
    if (mem_load) begin
      for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
      exp_b_dout = 8'h00;
    end else if (reset) begin
      exp_b_dout = 8'h00;
    end else begin
      if (bus0.b_ack) begin
        w = int'(bus0.b_addr[6:1]);
        if (bus0.b_we) begin
          if (bus0.b_addr[0]) exp_mem[w] = {bus0.b_din, exp_mem[w][7:0]};
          else                exp_mem[w] = {exp_mem[w][15:8], bus0.b_din};
          check("cmp_b_write_mem", {16'h0000, mem0[w]}, {16'h0000, exp_mem[w]});
        end else begin
          exp_b_dout = bus0.b_addr[0] ? exp_mem[w][15:8] : exp_mem[w][7:0];
        end
      end
      if (bus0.a_ack) begin
        w = int'(bus0.a_addr[6:1]);
        if (bus0.a_addr[0]) exp_mem[w] = {bus0.a_din, exp_mem[w][7:0]};
        else                exp_mem[w] = {exp_mem[w][15:8], bus0.a_din};
        check("cmp_a_write_mem", {16'h0000, mem0[w]}, {16'h0000, exp_mem[w]});
      end
      check("cmp_b_dout", {24'h0, bus0.b_dout}, {24'h0, exp_b_dout});
      check("cmp_we_without_oe", {31'h0, (!bus0.sram_we_n && !bus0.sram_dq_oe)}, 32'd0);
      check("cmp_dual_ack", {31'h0, (bus0.a_ack && bus0.b_ack)}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // One transaction on the default DUT; cycle 0 is the IDLE cycle in which req is sampled
  task automatic txn(input logic port, input logic we, input logic [21:0] addr,
                     input logic [7:0] din, input int exp_lat, input string name);
    logic we_tr [0:40];
    logic oe_tr [0:40];
    int lat = 0;
    int lows = 0;
    int f = 0;
    int l = 0;
    tick();
    if (port) begin
      bus0.b_we = we; bus0.b_addr = addr; bus0.b_din = din; bus0.b_req = 1'b1;
    end else begin
      bus0.a_addr = addr; bus0.a_din = din; bus0.a_req = 1'b1;
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      we_tr[k] = bus0.sram_we_n;
      oe_tr[k] = bus0.sram_dq_oe;
      if (!bus0.sram_we_n) begin
        lows++;
        if (f == 0) f = k;
        l = k;
      end
      if (port ? bus0.b_ack : bus0.a_ack) begin
        lat = k;
        break;
      end
    end
    bus0.a_req = 1'b0;
    bus0.b_req = 1'b0;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_we_low_cycles"}, lows, we ? 2 : 0);
    if (we) begin
      check({name, "_we_low_contiguous"}, l - f + 1, 2);
      check({name, "_oe_before_we"}, {31'h0, (f > 1) ? oe_tr[f-1] : 1'b0}, 32'd1);
      check({name, "_oe_after_we"}, {31'h0, (l < 40) ? oe_tr[l+1] : 1'b0}, 32'd1);
    end
  endtask

  // Same B transaction on both sweep instances, latency measured per instance
  task automatic sweep_txn(input logic we, input logic [21:0] addr, input logic [7:0] din,
                           input int lat1_exp, input int lat2_exp, input string name);
    int l1 = 0;
    int l2 = 0;
    tick();
    bus1.b_we = we; bus1.b_addr = addr; bus1.b_din = din; bus1.b_req = 1'b1;
    bus2.b_we = we; bus2.b_addr = addr; bus2.b_din = din; bus2.b_req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (l1 == 0 && bus1.b_ack) begin l1 = k; bus1.b_req = 1'b0; end
      if (l2 == 0 && bus2.b_ack) begin l2 = k; bus2.b_req = 1'b0; end
      if (l1 != 0 && l2 != 0) break;
    end
    bus1.b_req = 1'b0;
    bus2.b_req = 1'b0;
    check({name, "_lat_rd1_we1"}, l1, lat1_exp);
    check({name, "_lat_rd4_we3"}, l2, lat2_exp);
  endtask

  initial begin
    int order [4];
    int got;
    logic saw_low;
    bus0.a_req = 1'b0; bus0.a_addr = '0; bus0.a_din = 8'h00;
    bus0.b_req = 1'b0; bus0.b_we = 1'b0; bus0.b_addr = '0; bus0.b_din = 8'h00;
    bus1.a_req = 1'b0; bus1.a_addr = '0; bus1.a_din = 8'h00;
    bus1.b_req = 1'b0; bus1.b_we = 1'b0; bus1.b_addr = '0; bus1.b_din = 8'h00;
    bus2.a_req = 1'b0; bus2.a_addr = '0; bus2.a_din = 8'h00;
    bus2.b_req = 1'b0; bus2.b_we = 1'b0; bus2.b_addr = '0; bus2.b_din = 8'h00;
    repeat (3) tick();
    mem_load = 1'b0;

    check("rst_a_ack",   {31'h0, bus0.a_ack}, 32'd0);
    check("rst_b_ack",   {31'h0, bus0.b_ack}, 32'd0);
    check("rst_b_dout",  {24'h0, bus0.b_dout}, 32'd0);
    check("rst_sram_a",  {11'h0, bus0.sram_a}, 32'd0);
    check("rst_dq_o",    {16'h0, bus0.sram_dq_o}, 32'd0);
    check("rst_dq_oe",   {31'h0, bus0.sram_dq_oe}, 32'd0);
    check("rst_we_n",    {31'h0, bus0.sram_we_n}, 32'd1);
    reset = 1'b0;

    txn(1'b1, 1'b0, 22'h00003, 8'h00, 4, "b_read_odd");
    check("b_read_odd_value", {24'h0, bus0.b_dout}, 32'h0000_00A5);

    txn(1'b0, 1'b1, 22'h00010, 8'h3C, 9, "a_write_even");
    check("a_write_word8", {16'h0, mem0[8]}, 32'h0000_123C);
    check("a_keeps_b_dout", {24'h0, bus0.b_dout}, 32'h0000_00A5);

    // Simultaneous requests right after reset: A first, then strict alternation
    do_reset();
    tick();
    bus0.a_addr = 22'h00010; bus0.a_din = 8'h3C; bus0.a_req = 1'b1;
    bus0.b_we = 1'b0; bus0.b_addr = 22'h00003; bus0.b_req = 1'b1;
    for (int i = 0; i < 4; i++) order[i] = 2;
    got = 0;
    for (int k = 0; k < 80 && got < 4; k++) begin
      tick();
      if (bus0.a_ack && got < 4) begin order[got] = 0; got++; end
      if (bus0.b_ack && got < 4) begin order[got] = 1; got++; end
    end
    bus0.a_req = 1'b0;
    bus0.b_req = 1'b0;
    for (int i = 0; i < 4; i++) check("rr_grant_order", order[i], i % 2);

    txn(1'b1, 1'b1, 22'h00021, 8'hFF, 9, "b_write_odd");
    check("b_write_word16", {16'h0, mem0[16]}, 32'h0000_FF10);
    txn(1'b1, 1'b0, 22'h00020, 8'h00, 4, "b_read_even");
    check("b_read_even_lower_kept", {24'h0, bus0.b_dout}, 32'h0000_0010);
    txn(1'b1, 1'b0, 22'h00021, 8'h00, 4, "b_read_upper");
    check("b_read_upper_value", {24'h0, bus0.b_dout}, 32'h0000_00FF);

    // Reset during the write pulse; the byte written equals the stored one
    tick();
    bus0.b_we = 1'b1; bus0.b_addr = 22'h00020; bus0.b_din = 8'h10; bus0.b_req = 1'b1;
    saw_low = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!bus0.sram_we_n) begin saw_low = 1'b1; break; end
    end
    check("rst_mid_reached_wpul", {31'h0, saw_low}, 32'd1);
    reset = 1'b1;
    tick();
    check("rst_mid_we_n", {31'h0, bus0.sram_we_n}, 32'd1);
    check("rst_mid_oe",   {31'h0, bus0.sram_dq_oe}, 32'd0);
    check("rst_mid_no_ack", {30'h0, bus0.a_ack, bus0.b_ack}, 32'd0);
    tick();
    check("rst_mid_no_ack_2", {30'h0, bus0.a_ack, bus0.b_ack}, 32'd0);
    reset = 1'b0;
    bus0.b_req = 1'b0;
    txn(1'b1, 1'b0, 22'h00021, 8'h00, 4, "post_rst_read");
    check("post_rst_read_value", {24'h0, bus0.b_dout}, 32'h0000_00FF);

    do_reset();
    sweep_txn(1'b0, 22'h00003, 8'h00, 3, 6, "sweep_read");
    check("sweep_read_value_1", {24'h0, bus1.b_dout}, 32'h0000_00A5);
    check("sweep_read_value_2", {24'h0, bus2.b_dout}, 32'h0000_00A5);
    sweep_txn(1'b1, 22'h00004, 8'h77, 7, 12, "sweep_write");
    check("sweep_write_word_1", {16'h0, mem1[2]}, 32'h0000_1077);
    check("sweep_write_word_2", {16'h0, mem2[2]}, 32'h0000_1077);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
